// File: rtl/i2c_mem_pkg.sv
// i2c_mem_pkg: shared state type, R/W bit index and pointer wrap helper for the I2C memory controller
package i2c_mem_pkg;
  typedef enum logic [2:0] {IDLE, DEV, ADDR_HI, ADDR_LO, WDATA, RDATA, IGNORE} state_t;
  localparam int RW_BIT = 0;
  function automatic int unsigned next_addr(input int unsigned ptr, input int unsigned page_size, input int unsigned depth);
    int unsigned m;
    m = (page_size == 0) ? depth - 1 : page_size - 1;
    return ((ptr & ~m) | ((ptr + 1) & m)) & (depth - 1);
  endfunction
endpackage

// File: rtl/i2c_mem_addr_ptr.sv
// i2c_mem_addr_ptr: memory address pointer with load and page/linear wrapping increment
module i2c_mem_addr_ptr
  import i2c_mem_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int PAGE_SIZE = 0,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic          inc,
  input  logic [AW-1:0] load_val,
  output logic [AW-1:0] ptr
);
  always_ff @(posedge clk)
    if (!rst_n) ptr <= '0;
    else if (load) ptr <= load_val;
    else if (inc) ptr <= AW'(next_addr(32'(ptr), PAGE_SIZE, DEPTH));
endmodule

// File: rtl/i2c_mem_ctrl.sv
// i2c_mem_ctrl: I2C subordinate memory-side FSM driving a synchronous single-port RAM
module i2c_mem_ctrl
  import i2c_mem_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR = 7'h50,
  parameter int ADDR_BYTES = 1,
  parameter int DEPTH = 256,
  parameter int PAGE_SIZE = 0,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start_det,
  input  logic          stop_det,
  input  logic          byte_done,
  input  logic [7:0]    rx_byte,
  input  logic          ack_done,
  input  logic          mack_valid,
  input  logic          mack,
  input  logic          tx_load,
  input  logic          wp,
  input  logic [7:0]    mem_rdata,
  output logic          ack_req,
  output logic          rd_mode,
  output logic [AW-1:0] mem_addr,
  output logic [7:0]    mem_wdata,
  output logic          mem_we,
  output logic          mem_re,
  output logic [7:0]    tx_byte,
  output logic          tx_valid
);
  state_t state, state_n;
  logic ev, bd_live, dev_hit, dev_rd, hi_ld, ptr_load, wr_ok, acked, rd_inc, nack;
  logic ack_n, rd_mode_n, txv_n, re_n;
  logic mack_q, rd_pend, txv_q;
  logic [7:0] addr_hi, tx_hold;

  assign ev = start_det | stop_det;

  always_ff @(posedge clk) state <= !rst_n ? IDLE : state_n;

  always_comb begin
    state_n = state;
    if (start_det) state_n = DEV;
    else if (stop_det) state_n = IDLE;
    else
      case (state)
        DEV:     if (byte_done) state_n = rx_byte[7:1] != DEV_ADDR ? IGNORE : rx_byte[RW_BIT] ? RDATA : ADDR_BYTES == 2 ? ADDR_HI : ADDR_LO;
        ADDR_HI: if (byte_done) state_n = ADDR_LO;
        ADDR_LO: if (byte_done) state_n = WDATA;
        WDATA:   if (byte_done && wp) state_n = IGNORE;
        RDATA:   if (mack_valid && !mack) state_n = IGNORE;
        default: state_n = state;
      endcase
  end

  always_comb begin
    bd_live   = byte_done && !ev && state inside {DEV, ADDR_HI, ADDR_LO, WDATA};
    dev_hit   = bd_live && state == DEV && rx_byte[7:1] == DEV_ADDR;
    dev_rd    = dev_hit && rx_byte[RW_BIT];
    hi_ld     = bd_live && state == ADDR_HI;
    ptr_load  = bd_live && state == ADDR_LO;
    wr_ok     = bd_live && state == WDATA && !wp;
    acked     = dev_hit || hi_ld || ptr_load || wr_ok;
    rd_inc    = !ev && state == RDATA && mack_valid && mack;
    nack      = !ev && state == RDATA && mack_valid && !mack;
    ack_n     = acked || (!ev && !bd_live && !ack_done && ack_req);
    rd_mode_n = dev_rd || (!ev && rd_mode);
    txv_n     = !(ev || nack || tx_load) && (rd_pend || txv_q);
    re_n      = !ev && (dev_rd || mack_q);
  end

  always_ff @(posedge clk)
    if (!rst_n) begin
      ack_req   <= 1'b0;
      rd_mode   <= 1'b0;
      mem_we    <= 1'b0;
      mem_re    <= 1'b0;
      mem_wdata <= '0;
      mack_q    <= 1'b0;
      rd_pend   <= 1'b0;
      txv_q     <= 1'b0;
      addr_hi   <= '0;
      tx_hold   <= '0;
    end else begin
      ack_req <= ack_n;
      rd_mode <= rd_mode_n;
      mem_we  <= wr_ok;
      mem_re  <= re_n;
      mack_q  <= rd_inc;
      rd_pend <= mem_re && !ev;
      txv_q   <= txv_n;
      if (wr_ok) mem_wdata <= rx_byte;
      if (hi_ld) addr_hi <= rx_byte;
      if (rd_pend) tx_hold <= mem_rdata;
    end

  // RAM data is forwarded in its arrival cycle so the engine sees it one cycle after the read strobe
  assign tx_valid = txv_q || rd_pend;
  assign tx_byte  = rd_pend ? mem_rdata : tx_hold;

  i2c_mem_addr_ptr #(.DEPTH(DEPTH), .PAGE_SIZE(PAGE_SIZE)) u_ptr (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (ptr_load),
    .inc      (mem_we || rd_inc),
    .load_val (AW'({addr_hi, rx_byte})),
    .ptr      (mem_addr)
  );
endmodule

// File: tb/tb_i2c_mem_ctrl.sv
// tb_i2c_mem_ctrl: randomized scoreboard bench for i2c_mem_ctrl in a linear 1-byte and a paged 2-byte configuration
module tb_i2c_mem_ctrl;
  typedef struct { int k; int a; int d; } wr_t;
  typedef struct { int k; int d; } tx_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic init_copy = 1'b0;
  always #5 clk = ~clk;

  logic [1:0] start_det, stop_det, byte_done, ack_done, mack_valid, mack, tx_load, wp;
  logic [1:0][7:0] rx_byte, mem_rdata, mem_wdata, tx_byte;
  logic [1:0] ack_req, rd_mode, mem_we, mem_re, tx_valid;
  logic [7:0] ma0;
  logic [9:0] ma1;

  logic [7:0] ram [2][1024];
  logic [7:0] mm [2][1024];
  wr_t exp_wr[$];
  tx_t exp_tx[$];
  int mptr[2];
  bit ign[2];
  int checks = 0, failures = 0, re_seen = 0, re_exp = 0;

  i2c_mem_ctrl #(.DEV_ADDR(7'h50), .ADDR_BYTES(1), .DEPTH(256), .PAGE_SIZE(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .start_det(start_det[0]), .stop_det(stop_det[0]),
    .byte_done(byte_done[0]), .rx_byte(rx_byte[0]), .ack_done(ack_done[0]),
    .mack_valid(mack_valid[0]), .mack(mack[0]), .tx_load(tx_load[0]), .wp(wp[0]),
    .mem_rdata(mem_rdata[0]), .ack_req(ack_req[0]), .rd_mode(rd_mode[0]), .mem_addr(ma0),
    .mem_wdata(mem_wdata[0]), .mem_we(mem_we[0]), .mem_re(mem_re[0]),
    .tx_byte(tx_byte[0]), .tx_valid(tx_valid[0])
  );

  i2c_mem_ctrl #(.DEV_ADDR(7'h50), .ADDR_BYTES(2), .DEPTH(1024), .PAGE_SIZE(16)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start_det(start_det[1]), .stop_det(stop_det[1]),
    .byte_done(byte_done[1]), .rx_byte(rx_byte[1]), .ack_done(ack_done[1]),
    .mack_valid(mack_valid[1]), .mack(mack[1]), .tx_load(tx_load[1]), .wp(wp[1]),
    .mem_rdata(mem_rdata[1]), .ack_req(ack_req[1]), .rd_mode(rd_mode[1]), .mem_addr(ma1),
    .mem_wdata(mem_wdata[1]), .mem_we(mem_we[1]), .mem_re(mem_re[1]),
    .tx_byte(tx_byte[1]), .tx_valid(tx_valid[1])
  );

  function automatic int addr_of(input int k);
    return k != 0 ? int'(ma1) : int'(ma0);
  endfunction

  function automatic int tnext(input int k, input int a);
    int d, p;
    d = k != 0 ? 1024 : 256;
    p = k != 0 ? 16 : 0;
    return p == 0 ? (a + 1) % d : a - a % p + (a % p + 1) % p;
  endfunction

  always @(posedge clk)
    for (int k = 0; k < 2; k++) begin
      if (init_copy) for (int i = 0; i < 1024; i++) ram[k][i] <= mm[k][i];
      if (mem_we[k]) ram[k][addr_of(k)] <= mem_wdata[k];
      if (mem_re[k]) mem_rdata[k] <= ram[k][addr_of(k)];
    end

  always @(negedge clk)
    for (int k = 0; k < 2; k++) begin
      wr_t e;
      tx_t t;
      if (mem_re[k]) re_seen++;
      if (mem_we[k]) begin
        checks++;
        if (exp_wr.size() == 0) begin
          failures++;
          $display("FAIL mem_write unexpected k=%0d addr=%0h data=%0h required no write", k, addr_of(k), mem_wdata[k]);
        end else begin
          e = exp_wr.pop_front();
          if (e.k != k || e.a != addr_of(k) || e.d != int'(mem_wdata[k])) begin
            failures++;
            $display("FAIL mem_write k=%0d addr=%0h data=%0h required k=%0d addr=%0h data=%0h", k, addr_of(k), mem_wdata[k], e.k, e.a, e.d);
          end
        end
      end
      if (tx_load[k] && tx_valid[k]) begin
        checks++;
        if (exp_tx.size() == 0) begin
          failures++;
          $display("FAIL tx_byte unexpected k=%0d byte=%0h required none", k, tx_byte[k]);
        end else begin
          t = exp_tx.pop_front();
          if (t.k != k || t.d != int'(tx_byte[k])) begin
            failures++;
            $display("FAIL tx_byte k=%0d byte=%0h required k=%0d byte=%0h", k, tx_byte[k], t.k, t.d);
          end
        end
      end
    end

  task automatic chk(input string name, input int act, input int ex);
    checks++;
    if (act !== ex) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, ex);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ev_pulse(input int k, input bit s, input bit p);
    start_det[k] = s;
    stop_det[k] = p;
    tick();
    start_det[k] = 1'b0;
    stop_det[k] = 1'b0;
  endtask

  task automatic send(input int k, input int b, output bit ackd);
    rx_byte[k] = 8'(b);
    byte_done[k] = 1'b1;
    tick();
    byte_done[k] = 1'b0;
    ack_done[k] = 1'b1;
    @(negedge clk);
    ackd = ack_req[k];
    tick();
    ack_done[k] = 1'b0;
  endtask

  task automatic chk_zero(input int k, input string name);
    @(negedge clk);
    chk({name, "_outs"}, int'({ack_req[k], rd_mode[k], mem_we[k], mem_re[k], tx_valid[k], tx_byte[k], mem_wdata[k]}), 0);
    chk({name, "_addr"}, addr_of(k), 0);
  endtask

  task automatic set_addr(input int k, input int a);
    bit ackd;
    ev_pulse(k, 1'b1, 1'b0);
    ign[k] = 1'b0;
    send(k, 8'hA0, ackd);
    chk("dev_ack", int'(ackd), 1);
    @(negedge clk);
    chk("ack_clear", int'(ack_req[k]), 0);
    if (k != 0) begin
      send(k, (a >> 8) & 255, ackd);
      chk("addr_hi_ack", int'(ackd), 1);
    end
    send(k, a & 255, ackd);
    chk("addr_lo_ack", int'(ackd), 1);
    mptr[k] = k != 0 ? (a & 16'hFFFF) % 1024 : a & 255;
  endtask

  task automatic wr_byte(input int k, input int d, input bit wpv);
    bit ackd, ex;
    ex = !ign[k] && !wpv;
    if (ex) begin
      exp_wr.push_back(wr_t'{k, mptr[k], d});
      mm[k][mptr[k]] = 8'(d);
      mptr[k] = tnext(k, mptr[k]);
    end else ign[k] = 1'b1;
    wp[k] = wpv;
    send(k, d, ackd);
    wp[k] = 1'b0;
    chk("wr_ack", int'(ackd), int'(ex));
  endtask

  task automatic end_txn(input int k);
    ev_pulse(k, 1'b0, 1'b1);
    @(negedge clk);
    chk("pointer", addr_of(k), mptr[k]);
  endtask

  task automatic rd_bytes(input int k, input int n);
    bit ackd;
    int cnt;
    ev_pulse(k, 1'b1, 1'b0);
    send(k, 8'hA1, ackd);
    chk("rd_dev_ack", int'(ackd), 1);
    for (int i = 0; i < n; i++) begin
      exp_tx.push_back(tx_t'{k, int'(mm[k][mptr[k]])});
      re_exp++;
      cnt = 0;
      @(negedge clk);
      while (!tx_valid[k] && cnt < 8) begin
        @(negedge clk);
        cnt++;
      end
      chk("rd_latency", cnt, i == 0 ? 0 : 2);
      if (i == 0) chk("rd_mode", int'(rd_mode[k]), 1);
      tick();
      tx_load[k] = 1'b1;
      tick();
      tx_load[k] = 1'b0;
      @(negedge clk);
      chk("tx_clear", int'(tx_valid[k]), 0);
      tick();
      mack[k] = i < n - 1;
      mack_valid[k] = 1'b1;
      tick();
      mack_valid[k] = 1'b0;
      mack[k] = 1'b0;
      if (i < n - 1) mptr[k] = tnext(k, mptr[k]);
    end
    cnt = 0;
    repeat (4) begin
      @(negedge clk);
      cnt += int'(mem_re[k] | tx_valid[k]);
    end
    chk("nack_quiet", cnt, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ackd;
    int k, a, n;
    {start_det, stop_det, byte_done, ack_done, mack_valid, mack, tx_load, wp} = '0;
    rx_byte = '0;
    for (int j = 0; j < 2; j++) for (int i = 0; i < 1024; i++) mm[j][i] = 8'($urandom);
    mm[0][32] = 8'h3C;
    mm[0][33] = 8'h7E;
    init_copy = 1'b1;
    repeat (3) tick();
    init_copy = 1'b0;
    rst_n = 1'b1;
    chk_zero(0, "reset0");
    chk_zero(1, "reset1");
    mptr[0] = 0;
    mptr[1] = 0;

    set_addr(0, 8'h10);
    wr_byte(0, 8'h55, 1'b0);
    wr_byte(0, 8'h66, 1'b0);
    end_txn(0);
    chk("ptr_0x12", addr_of(0), 8'h12);

    set_addr(0, 8'h20);
    rd_bytes(0, 2);
    end_txn(0);
    chk("rd_mode_clear", int'(rd_mode[0]), 0);

    set_addr(0, 8'hFF);
    wr_byte(0, $urandom_range(0, 255), 1'b0);
    wr_byte(0, $urandom_range(0, 255), 1'b0);
    end_txn(0);

    set_addr(1, 16'h001E);
    repeat (3) wr_byte(1, $urandom_range(0, 255), 1'b0);
    end_txn(1);
    set_addr(1, 16'h03FE);
    wr_byte(1, 8'hAA, 1'b0);
    end_txn(1);
    set_addr(1, 16'hFFFE);
    wr_byte(1, $urandom_range(0, 255), 1'b0);
    end_txn(1);

    ev_pulse(0, 1'b1, 1'b0);
    send(0, 8'hB0, ackd);
    chk("mismatch_ack", int'(ackd), 0);
    send(0, 8'h12, ackd);
    chk("ignore_ack", int'(ackd), 0);
    end_txn(0);

    set_addr(0, 8'h50);
    wr_byte(0, $urandom_range(0, 255), 1'b1);
    wr_byte(0, $urandom_range(0, 255), 1'b0);
    end_txn(0);

    set_addr(0, 8'h40);
    rx_byte[0] = 8'h11;
    byte_done[0] = 1'b1;
    rst_n = 1'b0;
    tick();
    byte_done[0] = 1'b0;
    rst_n = 1'b1;
    mptr[0] = 0;
    chk_zero(0, "rst_wdata");
    send(0, 8'hA0, ackd);
    chk("idle_after_rst", int'(ackd), 0);

    set_addr(0, 8'h33);
    start_det[0] = 1'b1;
    stop_det[0] = 1'b1;
    rst_n = 1'b0;
    tick();
    start_det[0] = 1'b0;
    stop_det[0] = 1'b0;
    rst_n = 1'b1;
    mptr[0] = 0;
    chk_zero(0, "rst_collide");
    send(0, 8'hA0, ackd);
    chk("idle_after_rst2", int'(ackd), 0);
    ev_pulse(0, 1'b1, 1'b1);
    send(0, 8'hA0, ackd);
    chk("collide_to_dev", int'(ackd), 1);
    end_txn(0);

    repeat (24) begin
      k = $urandom_range(0, 1);
      a = k != 0 ? $urandom_range(0, 65535) : $urandom_range(0, 255);
      set_addr(k, a);
      if ($urandom_range(0, 1) == 1) begin
        n = $urandom_range(1, 5);
        repeat (n) wr_byte(k, $urandom_range(0, 255), $urandom_range(0, 7) == 0);
      end else rd_bytes(k, $urandom_range(1, 4));
      end_txn(k);
    end

    repeat (4) tick();
    chk("wr_queue_empty", exp_wr.size(), 0);
    chk("tx_queue_empty", exp_tx.size(), 0);
    chk("mem_re_count", re_seen, re_exp);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
